fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the instruction queue entry count (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 SHALL have port clk  input  1  as the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  as the asynchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  as the fetch request to the instruction memory.
REQ-006 SHALL have port imem_addr  output  32  as the word-aligned byte address of the current request.
REQ-007 SHALL have port imem_ack  input  1  as the memory acknowledge; imem_rdata is valid in the same cycle.
REQ-008 SHALL have port imem_rdata  input  32  as the instruction word returned by memory.
REQ-009 SHALL have port redirect  input  1  as the branch/jump/jr taken pulse from the PC stage.
REQ-010 SHALL have port redirect_pc  input  32  as the redirect target; it is sampled when redirect=1.
REQ-011 SHALL have port instr_valid  output  1  to indicate that the queue head holds an instruction for decode.
REQ-012 SHALL have port instr  output  32  as the head instruction word (opcode, rs, rt, rd, imm, jump fields).
REQ-013 SHALL have port instr_pc  output  32  as the byte address of the head instruction.
REQ-014 SHALL have port instr_ready  input  1  as decode acceptance; the head is popped when instr_valid and instr_ready are both 1.

Function
REQ-015 SHALL use a state machine with states FETCH (request outstanding), FULL (queue full, no request) and DROP (discarding a stale response).
REQ-016 SHALL drive imem_req=1 exactly in FETCH and DROP, and SHALL hold imem_addr stable while imem_req=1 until imem_ack is received.
REQ-017 SHALL keep at most one request outstanding, and count plus outstanding requests SHALL never exceed DEPTH.
REQ-018 On imem_ack in FETCH without redirect, SHALL push {fetch_pc, imem_rdata}, set fetch_pc to fetch_pc+4 (modulo 2^32, wrapping FFFF_FFFC to 0000_0000), and enter FULL if the queue is then full, otherwise stay in FETCH.
REQ-019 SHALL drive instr_valid=(count!=0), and SHALL drive instr and instr_pc from registered head storage with zero-cycle presentation latency.
REQ-020 On a push and pop in the same cycle, SHALL leave count unchanged and SHALL return a first-in-first-out order.
REQ-021 In FULL, on a pop, SHALL enter FETCH in the next cycle with imem_addr=fetch_pc.
REQ-022 On redirect, SHALL flush the queue so that count=0 and instr_valid=0 in the next cycle; a pop in the same cycle SHALL be ignored.
REQ-023 On redirect, SHALL load fetch_pc with {redirect_pc[31:2],2'b00}, so that misaligned low bits are forced to zero.
REQ-024 On redirect with a request outstanding and no ack in that cycle, SHALL enter DROP while keeping the old imem_addr.
REQ-025 On redirect coinciding with imem_ack, or on redirect from FULL, SHALL discard the returned data and enter FETCH at the new target.
REQ-026 In DROP, on imem_ack, SHALL discard imem_rdata and enter FETCH at the latched target; a further redirect in DROP SHALL only update the target.
REQ-027 SHALL never assert instr_valid for an instruction fetched before the most recent redirect.

Reset
REQ-028 While reset=1, SHALL immediately force state=FETCH, fetch_pc=RESET_PC, count=0, instr_valid=0, instr=0 and instr_pc=0.
REQ-029 SHALL drive imem_req=0 during reset and SHALL assert it, with imem_addr=RESET_PC, in the first cycle after reset deasserts.
REQ-030 On reset during a request, SHALL abandon the outstanding request; the memory sees imem_req drop.

Structure
REQ-031 SHALL place XLEN=32, the default RESET_PC and the FETCH/FULL/DROP state encoding in shared package cpu_pkg.
REQ-032 SHALL implement queue storage in sub-module fq_fifo: a synchronous FIFO of width 64 ({pc, instr}) and depth DEPTH with push, pop, flush and count.

Verification
REQ-033 Bench SHALL cover: reset release, memory ack every cycle, instr_ready=1 -> instr_pc sequence 0,4,8,12 with instr equal to the ROM contents.
REQ-034 Bench SHALL cover: instr_ready=0, ack every cycle -> 4 entries then FULL, imem_req=0; one pop -> imem_req=1 next cycle at addr 16.
REQ-035 Bench SHALL cover: redirect to 0x40 while a request to 0x8 is pending and ack arrives 3 cycles later -> that data is dropped, next request is 0x40, and the first instr_pc is 0x40.
REQ-036 Bench SHALL cover: redirect to 0x103 coinciding with ack and pop -> queue empty next cycle, then imem_addr=0x100.
REQ-037 Bench SHALL cover: redirect_pc=0xFFFF_FFFC -> instr_pc sequence FFFF_FFFC, 0000_0000.
REQ-038 Bench SHALL cover: reset asserted mid-request with 3 entries queued -> instr_valid=0 and imem_req=0 immediately, then a fetch from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch-queue state encoding
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_FULL  = 2'd1,
    ST_DROP  = 2'd2
  } fq_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// rtl/fq_fifo.sv - register-based FIFO of {pc, instr} entries with flush
module fq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic          pop,
  input  logic          flush,
  output fq_entry_t     head,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fq_entry_t     mem_q [DEPTH];
  fq_entry_t     mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch engine feeding a small decode queue
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fq_state_e       state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after_pop;
  logic            push, pop;
  fq_entry_t       head;
  fq_entry_t       push_entry;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign imem_req    = !reset && (state_q != ST_FULL);
  assign imem_addr   = addr_q;
  assign push_entry  = '{pc: fetch_pc_q, instr: imem_rdata};

  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    push            = 1'b0;
    count_after_pop = count - CW'(pop);
    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          fetch_pc_d = word_align(redirect_pc);
          state_d    = imem_ack ? ST_FETCH : ST_DROP;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          if ((count_after_pop + 1'b1) == FULL_CNT) begin
            state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (redirect) begin
          fetch_pc_d = word_align(redirect_pc);
          state_d    = ST_FETCH;
        end else if (pop) begin
          state_d = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (redirect) begin
          fetch_pc_d = word_align(redirect_pc);
        end
        if (imem_ack) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    // The stale request keeps its address until memory answers it.
    addr_d = (state_d == ST_DROP) ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

endmodule
